condicionador_botoes: RTL and testbench
=======================================

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 50000, giving the debounce window in clock cycles (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1 bit: the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port botoes, input, 7 bits: raw asynchronous player buttons, 1 = pressed.
REQ-005 SHALL have port habilita, input, 1 bit: when 1, allows a new press to be accepted.
REQ-006 SHALL have port limpa, input, 1 bit: synchronous clear of jogada.
REQ-007 SHALL have port jogada, output, 7 bits: last accepted one-hot play, held.
REQ-008 SHALL have port jogadafeita, output, 1 bit: 1-cycle pulse when jogada is updated.
REQ-009 SHALL have port invalida, output, 1 bit: 1-cycle pulse when a multi-button press is rejected.
REQ-010 SHALL have port tem_jogada, output, 1 bit: 1 when any bit of botoes_s (defined in REQ-012) is 1.
REQ-011 SHALL have port db_estado, output, 2 bits: state code, with OCIOSO=0, ESTABILIZA=1, VALIDA=2, ESPERA_SOLTAR=3.

Function
REQ-012 SHALL pass botoes through a 2-flop synchronizer; the result, botoes_s, is the only form of the buttons used internally.
REQ-013 SHALL hold a 7-bit register amostra and a 16-bit counter cont.
REQ-014 In OCIOSO, when habilita=1 and botoes_s≠0, SHALL set amostra to botoes_s, clear cont, and go to ESTABILIZA; otherwise it SHALL stay in OCIOSO.
REQ-015 In ESTABILIZA, when habilita=0 or botoes_s=0, SHALL go to OCIOSO.
REQ-016 In ESTABILIZA, when botoes_s≠amostra and botoes_s≠0, SHALL load amostra with botoes_s, clear cont, and remain in ESTABILIZA.
REQ-017 In ESTABILIZA, when botoes_s=amostra and cont=DEBOUNCE_CICLOS-1, SHALL go to VALIDA; otherwise cont SHALL increment.
REQ-018 On the edge entering VALIDA, if amostra has exactly one bit set, SHALL load jogada with amostra; otherwise jogada SHALL be left unchanged.
REQ-019 In VALIDA (exactly one cycle), SHALL drive jogadafeita=1 if amostra is one-hot, else invalida=1; SHALL then go to ESPERA_SOLTAR with cont cleared.
REQ-020 In ESPERA_SOLTAR, any botoes_s≠0 SHALL clear cont.
REQ-021 In ESPERA_SOLTAR, botoes_s=0 SHALL increment cont; when cont=DEBOUNCE_CICLOS-1 with botoes_s=0, SHALL go to OCIOSO.
REQ-022 SHALL ignore habilita in VALIDA and ESPERA_SOLTAR.
REQ-023 With limpa=1, SHALL clear jogada to 0 on the next edge.
REQ-024 If limpa=1 on the edge entering VALIDA with a one-hot amostra, the capture SHALL win over the clear.
REQ-025 jogadafeita and invalida SHALL be Moore outputs of VALIDA, never both 1, and never high for more than one consecutive cycle.
REQ-026 Latency: with a one-hot press stable before edge 1, jogadafeita SHALL be 1 in the cycle following edge DEBOUNCE_CICLOS+3.
REQ-027 cont SHALL never exceed DEBOUNCE_CICLOS-1 and SHALL never wrap.
REQ-028 At most one jogadafeita or invalida SHALL be produced per press, regardless of press duration.

Reset
REQ-029 On reset=0, SHALL asynchronously set state=OCIOSO and clear synchronizer flops, amostra, cont, and jogada to 0.
REQ-030 During reset, jogadafeita=0, invalida=0, tem_jogada=0, and db_estado=0.
REQ-031 On reset asserted mid-operation (any state), SHALL abort with no jogadafeita or invalida pulse.
REQ-032 After reset release, SHALL require botoes_s≠0 in OCIOSO before any capture.

Verification (DEBOUNCE_CICLOS=4)
REQ-033 Press botoes=7'b0000100, held 20 cycles, habilita=1 -> jogada=7'b0000100 and jogadafeita=1 in the cycle after edge 7; exactly one pulse; db_estado returns to 0 four cycles after release is synchronized.
REQ-034 botoes toggles 0/0000010 every 2 cycles for 16 cycles, then held -> no pulse during the toggling; exactly one jogadafeita after stable hold; jogada=7'b0000010.
REQ-035 botoes=7'b0010001, held -> invalida=1 for one cycle; jogada unchanged; jogadafeita stays 0.
REQ-036 habilita=0 with a press held 10 cycles -> db_estado stays 0 and no pulses; raising habilita while still pressed -> capture after 4 stable cycles.
REQ-037 Reset asserted while in ESTABILIZA -> immediately db_estado=0 and jogada=0; no pulse follows after release.
REQ-038 limpa=1 on the VALIDA-entry edge with press 7'b1000000 -> jogada=7'b1000000; limpa=1 one cycle later -> jogada=0.

Source files
------------

// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module  : condicionador_botoes
// Purpose : Conditions seven raw player buttons into a single debounced,
//           one-hot play. Each press yields at most one event: a capture
//           (jogadafeita) or a rejection of a multi-button press (invalida).
//           The buttons must then stay released for a full debounce window
//           before another press can be accepted.
// Ports   : clock       - rising-edge clock
//           reset       - asynchronous active-low reset
//           botoes      - raw asynchronous buttons, 1 = pressed
//           habilita    - allows a new press to be accepted
//           limpa       - synchronous clear of jogada
//           jogada      - last accepted one-hot play (held)
//           jogadafeita - 1-cycle pulse when jogada is updated
//           invalida    - 1-cycle pulse when a multi-button press is rejected
//           tem_jogada  - any synchronized button is pressed
//           db_estado   - current state code, for debug
// Revision: 1.0 - initial release
// ============================================================================
module condicionador_botoes #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] botoes,
  input  logic       habilita,
  input  logic       limpa,
  output logic [6:0] jogada,
  output logic       jogadafeita,
  output logic       invalida,
  output logic       tem_jogada,
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESTABILIZA    = 2'd1,
    VALIDA        = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  localparam logic [15:0] C_ULTIMO = 16'(DEBOUNCE_CICLOS - 1);

  estado_t     r_estado;
  logic [6:0]  r_sinc1;
  logic [6:0]  r_sinc2;
  logic [6:0]  r_amostra;
  logic [15:0] r_cont;
  logic [6:0]  r_jogada;
  logic        r_jogadafeita;
  logic        r_invalida;

  logic [6:0]  w_botoes_s;
  logic        w_amostra_um;

  assign w_botoes_s   = r_sinc2;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign w_amostra_um = (r_amostra != 7'd0) &&
                        ((r_amostra & (r_amostra - 7'd1)) == 7'd0);

  // Two-flop synchronizer; nothing downstream sees the raw buttons.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1 <= 7'd0;
      r_sinc2 <= 7'd0;
    end else begin
      r_sinc1 <= botoes;
      r_sinc2 <= r_sinc1;
    end
  end

  // The pulse registers are loaded on the edge that enters VALIDA, so they
  // are high exactly while the FSM sits in VALIDA (Moore behaviour without a
  // combinational decode on the outputs).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado      <= OCIOSO;
      r_amostra     <= 7'd0;
      r_cont        <= 16'd0;
      r_jogada      <= 7'd0;
      r_jogadafeita <= 1'b0;
      r_invalida    <= 1'b0;
    end else begin
      r_jogadafeita <= 1'b0;
      r_invalida    <= 1'b0;
      // Clear first so a capture later in this block overrides it.
      if (limpa) r_jogada <= 7'd0;

      case (r_estado)
        OCIOSO: begin
          if (habilita && (w_botoes_s != 7'd0)) begin
            r_amostra <= w_botoes_s;
            r_cont    <= 16'd0;
            r_estado  <= ESTABILIZA;
          end
        end

        ESTABILIZA: begin
          if (!habilita || (w_botoes_s == 7'd0)) begin
            r_estado <= OCIOSO;
          end else if (w_botoes_s != r_amostra) begin
            // Pattern changed while bouncing: restart the window on it.
            r_amostra <= w_botoes_s;
            r_cont    <= 16'd0;
          end else if (r_cont == C_ULTIMO) begin
            r_estado <= VALIDA;
            if (w_amostra_um) begin
              r_jogada      <= r_amostra;
              r_jogadafeita <= 1'b1;
            end else begin
              r_invalida    <= 1'b1;
            end
          end else begin
            r_cont <= r_cont + 16'd1;
          end
        end

        VALIDA: begin
          r_cont   <= 16'd0;
          r_estado <= ESPERA_SOLTAR;
        end

        ESPERA_SOLTAR: begin
          // Any bounce back to pressed restarts the release window.
          if (w_botoes_s != 7'd0) begin
            r_cont <= 16'd0;
          end else if (r_cont == C_ULTIMO) begin
            r_cont   <= 16'd0;
            r_estado <= OCIOSO;
          end else begin
            r_cont <= r_cont + 16'd1;
          end
        end

        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign jogada      = r_jogada;
  assign jogadafeita = r_jogadafeita;
  assign invalida    = r_invalida;
  assign tem_jogada  = |w_botoes_s;
  assign db_estado   = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module  : tb_condicionador_botoes
// Purpose : Directed self-checking bench for condicionador_botoes with a
//           four-cycle debounce window. Inputs change 1 time unit after a
//           rising edge; outputs are sampled at that same point.
// Revision: 1.0 - initial release
// ============================================================================
module tb_condicionador_botoes;

  logic       clock;
  logic       reset;
  logic [6:0] botoes;
  logic       habilita;
  logic       limpa;
  logic [6:0] jogada;
  logic       jogadafeita;
  logic       invalida;
  logic       tem_jogada;
  logic [1:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pf    = 0;   // jogadafeita cycles seen by run()
  int n_inv   = 0;   // invalida cycles seen by run()
  int n_viol  = 0;   // both pulses high, or a pulse held two cycles
  int n_nz    = 0;   // cycles with db_estado != 0 while disabled
  logic prev_pulse = 1'b0;

  condicionador_botoes #(.DEBOUNCE_CICLOS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .habilita   (habilita),
    .limpa      (limpa),
    .jogada     (jogada),
    .jogadafeita(jogadafeita),
    .invalida   (invalida),
    .tem_jogada (tem_jogada),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One edge, then sample; pulse bookkeeping on every cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (jogadafeita === 1'b1) n_pf++;
    if (invalida === 1'b1) n_inv++;
    if ((jogadafeita & invalida) === 1'b1) n_viol++;
    if ((prev_pulse & (jogadafeita | invalida)) === 1'b1) n_viol++;
    prev_pulse = jogadafeita | invalida;
    if (db_estado !== 2'd0) n_nz++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset    = 1'b0;
    botoes   = 7'h7F;
    habilita = 1'b1;
    limpa    = 1'b0;

    // ---- reset state, with buttons pressed during reset
    run(3);
    check("rst_estado", 16'(db_estado), 16'd0);
    check("rst_jogada", 16'(jogada), 16'd0);
    check("rst_pf", 16'(jogadafeita), 16'd0);
    check("rst_inv", 16'(invalida), 16'd0);
    check("rst_tem", 16'(tem_jogada), 16'd0);
    botoes = 7'd0;
    reset  = 1'b1;
    run(3);
    check("idle_estado", 16'(db_estado), 16'd0);

    // ---- single press, latency and single pulse
    n_pf = 0; n_inv = 0;
    botoes = 7'b0000100;
    run(2);
    check("p1_tem", 16'(tem_jogada), 16'd1);
    run(1);
    check("p1_estab", 16'(db_estado), 16'd1);
    run(3);
    check("p1_pf_e6", 16'(jogadafeita), 16'd0);
    run(1);
    check("p1_pf_e7", 16'(jogadafeita), 16'd1);
    check("p1_jogada", 16'(jogada), 16'b0000100);
    check("p1_valida", 16'(db_estado), 16'd2);
    run(1);
    check("p1_pf_e8", 16'(jogadafeita), 16'd0);
    check("p1_espera", 16'(db_estado), 16'd3);
    run(12);
    check("p1_npulse", 16'(n_pf), 16'd1);
    botoes = 7'd0;
    run(2);
    check("p1_tem_rel", 16'(tem_jogada), 16'd0);
    run(3);
    check("p1_still_wait", 16'(db_estado), 16'd3);
    run(1);
    check("p1_ocioso", 16'(db_estado), 16'd0);

    // ---- bouncing press, then stable hold
    n_pf = 0; n_inv = 0;
    for (int k = 0; k < 4; k++) begin
      botoes = 7'b0000010; run(2);
      botoes = 7'd0;       run(2);
    end
    check("b_nopulse", 16'(n_pf + n_inv), 16'd0);
    botoes = 7'b0000010;
    run(15);
    check("b_onepulse", 16'(n_pf), 16'd1);
    check("b_jogada", 16'(jogada), 16'b0000010);
    botoes = 7'd0;
    run(8);
    check("b_ocioso", 16'(db_estado), 16'd0);

    // ---- multi-button press is rejected
    n_pf = 0; n_inv = 0;
    botoes = 7'b0010001;
    run(7);
    check("m_inv_e7", 16'(invalida), 16'd1);
    check("m_pf_e7", 16'(jogadafeita), 16'd0);
    check("m_jogada", 16'(jogada), 16'b0000010);
    run(1);
    check("m_inv_e8", 16'(invalida), 16'd0);
    run(7);
    check("m_ninv", 16'(n_inv), 16'd1);
    check("m_npf", 16'(n_pf), 16'd0);
    botoes = 7'd0;
    run(8);

    // ---- habilita low blocks acceptance; raising it captures
    n_pf = 0; n_inv = 0; n_nz = 0;
    habilita = 1'b0;
    botoes = 7'b0001000;
    run(10);
    check("h_estado0", 16'(n_nz), 16'd0);
    check("h_nopulse", 16'(n_pf + n_inv), 16'd0);
    habilita = 1'b1;
    run(4);
    check("h_pf_early", 16'(jogadafeita), 16'd0);
    run(1);
    check("h_pf", 16'(jogadafeita), 16'd1);
    check("h_jogada", 16'(jogada), 16'b0001000);
    botoes = 7'd0;
    run(8);

    // ---- reset during ESTABILIZA aborts
    n_pf = 0; n_inv = 0;
    botoes = 7'b0100000;
    run(4);
    check("r_estab", 16'(db_estado), 16'd1);
    reset = 1'b0;
    #1;
    check("r_async_estado", 16'(db_estado), 16'd0);
    check("r_async_jogada", 16'(jogada), 16'd0);
    botoes = 7'd0;
    run(2);
    reset = 1'b1;
    run(12);
    check("r_nopulse", 16'(n_pf + n_inv), 16'd0);
    check("r_jogada", 16'(jogada), 16'd0);

    // ---- capture beats limpa on VALIDA entry; limpa then clears
    botoes = 7'b1000000;
    run(6);
    limpa = 1'b1;
    run(1);
    check("l_pf", 16'(jogadafeita), 16'd1);
    check("l_capture", 16'(jogada), 16'b1000000);
    run(1);
    check("l_clear", 16'(jogada), 16'd0);
    limpa = 1'b0;
    botoes = 7'd0;
    run(8);

    check("pulse_shape", 16'(n_viol), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
